// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbiter slice:
//               byte width, default watchdog timeout, grant index width and
//               the arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int BYTE_W          = 8;
  localparam int ACK_TIMEOUT_DEF = 16;
  localparam int IDX_W           = 3;

  // Arbiter FSM state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin selector. Searches the request
//               vector starting just after the last-served index and wraps
//               modulo N_REQ; reports whether any request is set and which
//               index won.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Walk the candidates from farthest to nearest so the nearest hit after last_i wins
  always_comb begin
    int j;
    j       = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(last_i) + k) % N_REQ;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one uart_tx between N_REQ byte
//               producers. Accepts a byte via valid/ready, strobes it into
//               the transmitter, waits for tx_busy to rise and fall, and
//               aborts with err_timeout if busy never rises.
//               Optional macro UART_TX_ARB_LOCK_EN adds req_last so a
//               producer keeps the transmitter until it sends a last byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int CNT_W       = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        req_last,
`endif
  output logic [N_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_wr_enb,
  input  logic                    tx_busy,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    arb_active,
  output logic                    err_timeout
);

  localparam logic [IDX_W-1:0] c_LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] c_WD_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               active_q;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   w_req;
  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [N_REQ-1:0]   w_pick_oh;

  assign w_pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;

`ifdef UART_TX_ARB_LOCK_EN
  // lock_q: current owner must be re-granted; tail_q: req_last of the byte in flight
  logic               lock_q, lock_d;
  logic               tail_q, tail_d;
  logic [N_REQ-1:0]   w_grant_oh;

  assign w_grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
  // While locked only the current owner is eligible, so the picker returns it
  assign w_req      = lock_q ? (req_valid & w_grant_oh) : req_valid;
`else
  assign w_req      = req_valid;
`endif

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (w_req),
    .last_i  (last_q),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );

  // Next-state logic: grant, issue strobe, wait for busy to rise, wait for frame end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    data_d  = data_q;
    grant_d = grant_q;
    ready_d = '0;
    wr_d    = 1'b0;
    err_d   = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    lock_d  = lock_q;
    tail_d  = tail_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!tx_busy && w_pick_valid) begin
          ready_d = w_pick_oh;
          data_d  = req_data[BYTE_W*int'(w_pick_idx) +: BYTE_W];
          grant_d = w_pick_idx;
          state_d = ST_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
          tail_d  = |(req_last & w_pick_oh);
`endif
        end
      end
      ST_ISSUE: begin
        wr_d    = 1'b1;
        wdog_d  = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (wdog_q == c_WD_LAST) begin
          // Transmitter never acknowledged: give up, still rotate priority
          err_d   = 1'b1;
          last_d  = grant_q;
          state_d = ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_d  = ~tail_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= c_LAST_RST;
      wdog_q   <= '0;
      ready_q  <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      grant_q  <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wdog_q   <= wdog_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      grant_q  <= grant_d;
      active_q <= (state_d != ST_IDLE);
      err_q    <= err_d;
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  // Message-lock state, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      tail_q <= tail_d;
    end
  end
`endif

  assign req_ready   = ready_q;
  assign tx_data     = data_q;
  assign tx_wr_enb   = wr_q;
  assign grant_id    = grant_q;
  assign arb_active  = active_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire
